// File: rtl/instr_encoder.sv
// ============================================================================
// instr_encoder : builds MIPS instruction words and writes them to imem at an
// auto-incrementing byte address.  Optional macro: INSTR_ENC_COP0_EN (COP0 op)
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              err_illegal,
  output logic              wrapped,
  output logic [15:0]       word_count
);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_WRITE = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q, wrapped_q;
  logic [15:0]       count_q;

  logic [5:0]        w_funct, w_opc;
  logic [31:0]       w_word;
  logic              w_legal;
  logic              w_accept;
  logic [ADDR_W-1:0] w_addr_inc;
  logic              w_unused;

  assign w_unused = ^base_addr[1:0];

  always_comb begin
    w_funct = 6'b000000;
    case (in_op)
      5'd1:    w_funct = 6'b000010;
      5'd2:    w_funct = 6'b000011;
      5'd5:    w_funct = 6'b100000;
      5'd6:    w_funct = 6'b100001;
      5'd7:    w_funct = 6'b100010;
      5'd8:    w_funct = 6'b100100;
      5'd9:    w_funct = 6'b100101;
      5'd10:   w_funct = 6'b100111;
      5'd11:   w_funct = 6'b101010;
      5'd12:   w_funct = 6'b101011;
      default: w_funct = 6'b000000;
    endcase
  end

  always_comb begin
    w_opc = 6'b000000;
    case (in_op)
      5'd13:   w_opc = 6'b000010;
      5'd14:   w_opc = 6'b000011;
      5'd15:   w_opc = 6'b000100;
      5'd16:   w_opc = 6'b000101;
      5'd17:   w_opc = 6'b001000;
      5'd18:   w_opc = 6'b001001;
      5'd19:   w_opc = 6'b001010;
      5'd20:   w_opc = 6'b001100;
      5'd21:   w_opc = 6'b001101;
      5'd22:   w_opc = 6'b001110;
      5'd23:   w_opc = 6'b100011;
      5'd24:   w_opc = 6'b101011;
      default: w_opc = 6'b000000;
    endcase
  end

  always_comb begin
    w_legal = 1'b1;
    w_word  = 32'h0;
    case (in_op)
      5'd0, 5'd1, 5'd2:
        w_word = {11'b0, in_rt, in_rd, in_shamt, w_funct};
      5'd3:
        w_word = {6'b000000, in_rs, 15'b0, 6'b001000};
      5'd4:
        w_word = {26'b0, 6'b001100};
      5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12:
        w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, w_funct};
      5'd13, 5'd14:
        w_word = {w_opc, in_target};
      5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24:
        w_word = {w_opc, in_rs, in_rt, in_imm};
`ifdef INSTR_ENC_COP0_EN
      5'd25:
        w_word = {6'b010000, in_rs, in_rt, in_rd, 11'b0};
`endif
      default:
        w_legal = 1'b0;
    endcase
  end

  assign w_accept   = in_valid && in_ready;
  assign w_addr_inc = addr_q + ADDR_W'(4);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= c_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (w_accept && w_legal) state_d = c_WRITE;
      c_WRITE: if (mem_ack) state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // Output logic; base_load steals the IDLE cycle so no request collides with it
  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      c_IDLE:  in_ready = !base_load;
      c_WRITE: mem_we   = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      err_q     <= 1'b0;
      wrapped_q <= 1'b0;
      count_q   <= 16'h0;
    end else begin
      err_q <= w_accept && !w_legal;
      if (state_q == c_IDLE) begin
        if (base_load) addr_q <= {base_addr[ADDR_W-1:2], 2'b00};
        else if (w_accept && w_legal) wdata_q <= w_word;
      end else if (mem_ack) begin
        addr_q <= w_addr_inc;
        if (w_addr_inc == '0) wrapped_q <= 1'b1;
        if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
      end
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign err_illegal = err_q;
  assign wrapped     = wrapped_q;
  assign word_count  = count_q;

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder counterpart of the single-cycle control unit. It takes a symbolic operation and its fields, builds the 32-bit MIPS instruction word, and writes it into instruction memory at an auto-incrementing address.
- It is used by the boot/program loader to fill instruction memory before the core starts.
- The opcode and funct values it emits are exactly the ones the control unit decodes.

Parameters:
- ADDR_W, 10, width of the byte address into instruction memory. Bits [1:0] are always 0.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- base_load  in  1  pulse: load write pointer from base_addr
- base_addr  in  ADDR_W  new write pointer; bits [1:0] are ignored and forced to 0
- in_valid  in  1  operation request valid
- in_ready  out  1  encoder can accept a request
- in_op  in  5  operation select (see Behaviour)
- in_rs  in  5  rs field
- in_rt  in  5  rt field
- in_rd  in  5  rd field
- in_shamt  in  5  shift amount
- in_imm  in  16  immediate
- in_target  in  26  jump target
- mem_we  out  1  write request to instruction memory
- mem_addr  out  ADDR_W  write byte address
- mem_wdata  out  32  encoded instruction
- mem_ack  in  1  memory accepted the write
- err_illegal  out  1  one-cycle pulse: in_op not supported
- wrapped  out  1  sticky: write pointer wrapped past the top of memory
- word_count  out  16  number of words written since reset (saturating)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, err_illegal=0, wrapped=0, word_count=0.
- in_op map (R-type funct / non-R opcode):
  - R-type, opcode 000000, funct as listed: 0 SLL 000000, 1 SRL 000010, 2 SRA 000011, 3 JR 001000, 4 SYSCALL 001100, 5 ADD 100000, 6 ADDU 100001, 7 SUB 100010, 8 AND 100100, 9 OR 100101, 10 NOR 100111, 11 SLT 101010, 12 SLTU 101011.
  - Opcodes: 13 J 000010, 14 JAL 000011, 15 BEQ 000100, 16 BNE 000101, 17 ADDI 001000, 18 ADDIU 001001, 19 SLTI 001010, 20 ANDI 001100, 21 ORI 001101, 22 XORI 001110, 23 LW 100011, 24 SW 101011.
  - 25 is COP0 (optional, see Optional Feature). 26-31 are illegal.
- Formats:
  - General R-type: {000000, rs, rt, rd, shamt, funct}.
  - SLL/SRL/SRA: rs forced to 0.
  - Other R-type except JR/SYSCALL: shamt forced to 0.
  - JR: {000000, rs, 15'b0, 001000}.
  - SYSCALL: {26'b0, 001100}.
  - J/JAL: {op, target}.
  - I-type: {op, rs, rt, imm}.
  - Unused input fields are ignored.
- FSM:
  - IDLE:
    - in_ready=1.
    - base_load has priority. In that cycle in_ready=0, mem_addr <= {base_addr[ADDR_W-1:2],2'b0}, and wrapped is unchanged.
    - On in_valid&in_ready with a legal op: register the encoded word into mem_wdata, go to WRITE.
    - On in_valid&in_ready with an illegal op: err_illegal=1 next cycle for one cycle only, no write, mem_addr unchanged, stay in IDLE.
  - WRITE:
    - in_ready=0. mem_we=1 with mem_addr and mem_wdata stable until mem_ack.
    - mem_ack may arrive in the first WRITE cycle or any later cycle.
    - On mem_ack:
      - mem_we=0 next cycle.
      - mem_addr += 4 modulo 2^ADDR_W. Wrap to 0 sets wrapped.
      - word_count += 1, saturating at 0xFFFF.
      - Return to IDLE.
    - base_load is ignored in WRITE.
- Throughput: at most one word per 2 cycles. The request is accepted in IDLE; mem_we rises the next cycle.
- mem_ack outside WRITE is ignored.
- Reset during WRITE: mem_we drops immediately (asynchronously). The pending word is discarded and the pointer returns to 0.

Optional Feature:
- INSTR_ENC_COP0_EN defined: in_op=25 encodes {010000, rs, rt, rd, 11'b0}, where rs is the COP0 sub-op (MFC0=00000, MTC0=00100).
- Undefined: in_op=25 is illegal and raises err_illegal.

Test Plan:
- ADD, rs=1 rt=2 rd=3, after reset, mem_ack same cycle as mem_we -> mem_addr=0x000, mem_wdata=0x00221820; next pointer 0x004, word_count=1.
- Sequence ADDI rs=0 rt=8 imm=0x0005, then SLL rt=5 rd=4 shamt=2, then J target=0x0100000 -> 0x20080005 @0x000, 0x00052080 @0x004, 0x08100000 @0x008.
- in_op=31 -> err_illegal high exactly 1 cycle; mem_we never asserts; pointer and word_count unchanged.
- mem_ack delayed 3 cycles -> mem_we, mem_addr, mem_wdata stable for all 4 WRITE cycles; in_ready=0 throughout; in_valid held high is not accepted until IDLE.
- base_load base_addr=0x3FE (ADDR_W=10), then one write -> written at 0x3FC; pointer becomes 0x000; wrapped=1 and stays 1.
- With INSTR_ENC_COP0_EN, in_op=25 rs=4 rt=9 rd=12 -> 0x40896000. Without the macro -> err_illegal pulse, no write.
